// File: rtl/bar_accumulator_if.sv
// Magnitude stream handshake between the spectrum stage and bar_accumulator.
// One bin per accepted beat (valid && ready); last marks the final bin of a frame.
interface bar_accumulator_if #(
  parameter int BAR_WIDTH = 16
);
  logic                 mag_valid;
  logic [BAR_WIDTH-1:0] mag_data;
  logic                 mag_last;
  logic                 mag_ready;

  modport master (
    output mag_valid,
    output mag_data,
    output mag_last,
    input  mag_ready
  );

  modport slave (
    input  mag_valid,
    input  mag_data,
    input  mag_last,
    output mag_ready
  );
endinterface

// File: rtl/bar_accumulator.sv
// bar_accumulator: reduces a streamed spectrum frame to one peak per bar and
// publishes the bar heights on a frame-sync pulse, so a redraw never mixes
// two analysis frames.
// Optional feature macro: BAR_DECAY_EN -- peak-hold with a linear fall of
// DECAY_STEP per committed frame. Without it each published frame is exactly
// that frame's per-bar maxima.
module bar_accumulator #(
  parameter int NUM_BARS     = 16,
  parameter int BAR_WIDTH    = 16,
  parameter int BINS_PER_BAR = 4,
  parameter int DECAY_STEP   = 512
) (
  input  logic                 fsm_clk,
  input  logic                 reset,
  bar_accumulator_if.slave     mag,
  input  logic                 frame_sync,
  output logic [BAR_WIDTH-1:0] bars [NUM_BARS],
  output logic                 frame_done
);

  localparam int TOTAL_BINS = NUM_BARS * BINS_PER_BAR;
  localparam int BIN_W      = $clog2(TOTAL_BINS + 1);
  localparam int IDX_W      = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  localparam logic [BIN_W-1:0]     BIN_MAX = BIN_W'(TOTAL_BINS);
  localparam logic [BIN_W-1:0]     BIN_DIV = BIN_W'(BINS_PER_BAR);
  localparam logic [IDX_W-1:0]     K_LAST  = IDX_W'(NUM_BARS - 1);
  localparam logic [BAR_WIDTH-1:0] DECAY_W = BAR_WIDTH'(DECAY_STEP);
  localparam logic [BAR_WIDTH-1:0] ZERO_W  = {BAR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_ACCUM     = 2'd0,
    ST_COMMIT    = 2'd1,
    ST_WAIT_SYNC = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [BIN_W-1:0]     bin_r;
  logic [IDX_W-1:0]     k_r;
  logic [BAR_WIDTH-1:0] acc_r  [NUM_BARS];
  logic [BAR_WIDTH-1:0] held_r [NUM_BARS];

  logic                 ready_s;
  logic                 commit_s;
  logic                 publish_s;
  logic                 accept_s;
  logic [BIN_W-1:0]     bin_div_s;
  logic [NUM_BARS-1:0]  bar_sel_s;
  logic [BAR_WIDTH-1:0] acc_k_s;
  logic [BAR_WIDTH-1:0] new_held_s;

  assign mag.mag_ready = ready_s;
  assign accept_s      = mag.mag_valid & ready_s;

  // State register.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a frame ends on an accepted last beat, the commit sweep
  // runs once per bar, and only a sync seen while waiting releases the frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (accept_s && mag.mag_last) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_COMMIT: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ST_WAIT_SYNC;
        end else begin
          state_nxt_s = ST_COMMIT;
        end
      end
      ST_WAIT_SYNC: begin
        if (frame_sync) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_WAIT_SYNC;
        end
      end
      default: state_nxt_s = ST_ACCUM;
    endcase
  end

  // State decode: ready only in ACCUM and never while reset is held.
  always_comb begin
    ready_s   = 1'b0;
    commit_s  = 1'b0;
    publish_s = 1'b0;
    case (state_r)
      ST_ACCUM:     ready_s   = ~reset;
      ST_COMMIT:    commit_s  = 1'b1;
      ST_WAIT_SYNC: publish_s = frame_sync;
      default: begin
        ready_s   = 1'b0;
        commit_s  = 1'b0;
        publish_s = 1'b0;
      end
    endcase
  end

  // Decode which bar the current bin belongs to; saturated bins select none.
  always_comb begin
    bin_div_s = bin_r / BIN_DIV;
    bar_sel_s = {NUM_BARS{1'b0}};
    for (int b = 0; b < NUM_BARS; b++) begin
      if (bin_div_s == BIN_W'(b)) begin
        bar_sel_s[b] = 1'b1;
      end else begin
        bar_sel_s[b] = 1'b0;
      end
    end
  end

  // New held value for the bar being committed this cycle.
`ifdef BAR_DECAY_EN
  logic [BAR_WIDTH-1:0] held_k_s;
  logic [BAR_WIDTH-1:0] decayed_s;

  always_comb begin
    acc_k_s  = acc_r[k_r];
    held_k_s = held_r[k_r];
    if (held_k_s > DECAY_W) begin
      decayed_s = held_k_s - DECAY_W;
    end else begin
      decayed_s = ZERO_W;
    end
    if (acc_k_s > decayed_s) begin
      new_held_s = acc_k_s;
    end else begin
      new_held_s = decayed_s;
    end
  end
`else
  logic unused_decay_s;
  assign unused_decay_s = ^DECAY_W;

  always_comb begin
    acc_k_s    = acc_r[k_r];
    new_held_s = acc_k_s;
  end
`endif

  // Bin counter (saturating) and commit sweep index.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      bin_r <= {BIN_W{1'b0}};
      k_r   <= {IDX_W{1'b0}};
    end else if (commit_s) begin
      if (k_r == K_LAST) begin
        k_r   <= {IDX_W{1'b0}};
        bin_r <= {BIN_W{1'b0}};
      end else begin
        k_r <= k_r + IDX_W'(1);
      end
    end else if (accept_s && (bin_r != BIN_MAX)) begin
      bin_r <= bin_r + BIN_W'(1);
    end
  end

  // Per-bar running maximum; each bar is cleared as the sweep commits it.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARS; b++) begin
        acc_r[b] <= ZERO_W;
      end
    end else begin
      for (int b = 0; b < NUM_BARS; b++) begin
        if (commit_s && (k_r == IDX_W'(b))) begin
          acc_r[b] <= ZERO_W;
        end else if (accept_s && bar_sel_s[b] && (mag.mag_data > acc_r[b])) begin
          acc_r[b] <= mag.mag_data;
        end
      end
    end
  end

  // Held values: one bar written per commit cycle.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARS; b++) begin
        held_r[b] <= ZERO_W;
      end
    end else if (commit_s) begin
      held_r[k_r] <= new_held_s;
    end
  end

  // Published bars: all copied on one edge, plus a one-cycle done pulse.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARS; b++) begin
        bars[b] <= ZERO_W;
      end
      frame_done <= 1'b0;
    end else begin
      if (publish_s) begin
        for (int b = 0; b < NUM_BARS; b++) begin
          bars[b] <= held_r[b];
        end
      end
      frame_done <= publish_s;
    end
  end

endmodule

// File: tb/tb_bar_accumulator.sv
// Directed testbench for bar_accumulator. Expected values are hand-computed
// for both builds; BAR_DECAY_EN selects the decay-mode expectations.
module tb_bar_accumulator;

  localparam int NB  = 16;
  localparam int BW  = 16;
  localparam int BPB = 4;
`ifdef BAR_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif

  logic          fsm_clk    = 1'b0;
  logic          reset      = 1'b1;
  logic          frame_sync = 1'b0;
  logic [BW-1:0] bars [NB];
  logic          frame_done;
  logic [BW-1:0] fd [128];
  int            checks = 0;
  int            errors = 0;

  bar_accumulator_if #(.BAR_WIDTH(BW)) mag ();

  bar_accumulator #(
    .NUM_BARS(NB), .BAR_WIDTH(BW), .BINS_PER_BAR(BPB), .DECAY_STEP(512)
  ) dut (
    .fsm_clk(fsm_clk), .reset(reset), .mag(mag), .frame_sync(frame_sync),
    .bars(bars), .frame_done(frame_done)
  );

  always #5 fsm_clk = ~fsm_clk;

  task automatic tick();
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [BW-1:0] v);
    for (int i = 0; i < n; i++) fd[i] = v;
  endtask

  task automatic send_frame(input int n, input bit keep_valid);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      mag.mag_valid = 1'b1;
      mag.mag_data  = fd[i];
      mag.mag_last  = (i == n - 1);
      while (mag.mag_ready !== 1'b1 && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %0d ready=%b, required 1", i, mag.mag_ready);
      end
      tick();
    end
    mag.mag_last = 1'b0;
    if (!keep_valid) mag.mag_valid = 1'b0;
  endtask

  task automatic wait_commit();
    repeat (NB + 1) tick();
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (mag.mag_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", mag.mag_ready); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", frame_done); end
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (bars[b] !== 16'd0) begin errors++; $display("FAIL reset_bar%0d: got %0d, required 0", b, bars[b]); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mag.mag_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", mag.mag_ready); end
  endtask

  task automatic test_peak();
    int pulses;
    fill(64, 16'd100);
    fd[5] = 16'd9000;
    send_frame(64, 1'b0);
    wait_commit();
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL peak_done_early: got %b, required 0", frame_done); end
    pulse_sync();
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL peak_done: got %b, required 1", frame_done); end
    checks++;
    if (bars[1] !== 16'd9000) begin errors++; $display("FAIL peak_bar1: got %0d, required 9000", bars[1]); end
    checks++;
    if (bars[0] !== 16'd100) begin errors++; $display("FAIL peak_bar0: got %0d, required 100", bars[0]); end
    checks++;
    if (bars[15] !== 16'd100) begin errors++; $display("FAIL peak_bar15: got %0d, required 100", bars[15]); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL peak_done_once: extra pulses %0d, required 0", pulses); end
  endtask

  task automatic test_decay();
    fill(64, 16'd0);
    send_frame(64, 1'b0);
    wait_commit();
    pulse_sync();
    checks++;
    if (bars[1] !== (DECAY_ON ? 16'd8488 : 16'd0)) begin errors++; $display("FAIL decay1_bar1: got %0d, required %0d", bars[1], DECAY_ON ? 8488 : 0); end
    checks++;
    if (bars[0] !== 16'd0) begin errors++; $display("FAIL decay1_bar0: got %0d, required 0", bars[0]); end
    send_frame(64, 1'b0);
    wait_commit();
    pulse_sync();
    checks++;
    if (bars[1] !== (DECAY_ON ? 16'd7976 : 16'd0)) begin errors++; $display("FAIL decay2_bar1: got %0d, required %0d", bars[1], DECAY_ON ? 7976 : 0); end
  endtask

  task automatic test_gating();
    int bad_ready;
    int bad_bars;
    fill(64, 16'd1000);
    frame_sync = 1'b1;
    send_frame(64, 1'b0);
    frame_sync = 1'b0;
    repeat (3) tick();
    pulse_sync();
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL gate_done_commit: got %b, required 0", frame_done); end
    bad_ready = 0;
    bad_bars  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mag.mag_ready !== 1'b0) bad_ready++;
      if (bars[0] !== 16'd0) bad_bars++;
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL gate_ready_low: cycles with ready=1 %0d, required 0", bad_ready); end
    checks++;
    if (bad_bars !== 0) begin errors++; $display("FAIL gate_bars_stable: changed cycles %0d, required 0", bad_bars); end
    pulse_sync();
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL gate_done: got %b, required 1", frame_done); end
    checks++;
    if (bars[0] !== 16'd1000) begin errors++; $display("FAIL gate_bar0: got %0d, required 1000", bars[0]); end
    checks++;
    if (bars[1] !== (DECAY_ON ? 16'd7464 : 16'd1000)) begin errors++; $display("FAIL gate_bar1: got %0d, required %0d", bars[1], DECAY_ON ? 7464 : 1000); end
    checks++;
    if (mag.mag_ready !== 1'b1) begin errors++; $display("FAIL gate_ready_after: got %b, required 1", mag.mag_ready); end
  endtask

  task automatic test_latency();
    int cnt;
    logic [BW-1:0] exp_v;
    exp_v = DECAY_ON ? 16'd488 : 16'd77;
    fill(64, 16'd77);
    frame_sync = 1'b1;
    send_frame(64, 1'b0);
    cnt = 1;
    while (bars[0] !== exp_v && cnt < 40) begin
      tick();
      cnt++;
    end
    frame_sync = 1'b0;
    checks++;
    if (cnt !== 18) begin errors++; $display("FAIL latency: got %0d cycles, required 18", cnt); end
    checks++;
    if (bars[0] !== exp_v) begin errors++; $display("FAIL latency_bar0: got %0d, required %0d", bars[0], exp_v); end
    tick();
  endtask

  task automatic test_short_long();
    for (int i = 0; i < 10; i++) fd[i] = 16'(1000 * (i + 1));
    send_frame(10, 1'b0);
    wait_commit();
    pulse_sync();
    checks++;
    if (bars[0] !== 16'd4000) begin errors++; $display("FAIL short_bar0: got %0d, required 4000", bars[0]); end
    checks++;
    if (bars[1] !== 16'd8000) begin errors++; $display("FAIL short_bar1: got %0d, required 8000", bars[1]); end
    checks++;
    if (bars[2] !== 16'd10000) begin errors++; $display("FAIL short_bar2: got %0d, required 10000", bars[2]); end
    checks++;
    if (bars[3] !== 16'd0) begin errors++; $display("FAIL short_bar3: got %0d, required 0", bars[3]); end
    checks++;
    if (bars[15] !== 16'd0) begin errors++; $display("FAIL short_bar15: got %0d, required 0", bars[15]); end
    fill(64, 16'd300);
    for (int i = 64; i < 80; i++) fd[i] = 16'd60000;
    send_frame(80, 1'b0);
    wait_commit();
    pulse_sync();
    checks++;
    if (bars[15] !== 16'd300) begin errors++; $display("FAIL long_bar15: got %0d, required 300", bars[15]); end
    checks++;
    if (bars[14] !== 16'd300) begin errors++; $display("FAIL long_bar14: got %0d, required 300", bars[14]); end
    checks++;
    if (bars[0] !== (DECAY_ON ? 16'd3488 : 16'd300)) begin errors++; $display("FAIL long_bar0: got %0d, required %0d", bars[0], DECAY_ON ? 3488 : 300); end
  endtask

  task automatic test_back_to_back();
    int bad_ready;
    fill(64, 16'd200);
    send_frame(64, 1'b1);
    mag.mag_data = 16'd12345;
    bad_ready = 0;
    for (int i = 0; i < NB + 1; i++) begin
      if (mag.mag_ready !== 1'b0) bad_ready++;
      tick();
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL bp_ready_low: cycles with ready=1 %0d, required 0", bad_ready); end
    pulse_sync();
    checks++;
    if (bars[3] !== 16'd200) begin errors++; $display("FAIL bp_frameA_bar3: got %0d, required 200", bars[3]); end
    fd[0] = 16'd12345;
    for (int i = 1; i < 64; i++) fd[i] = 16'd10;
    send_frame(64, 1'b0);
    wait_commit();
    pulse_sync();
    checks++;
    if (bars[0] !== 16'd12345) begin errors++; $display("FAIL bp_bar0: got %0d, required 12345", bars[0]); end
    checks++;
    if (bars[3] !== 16'd10) begin errors++; $display("FAIL bp_bar3: got %0d, required 10", bars[3]); end
    checks++;
    if (bars[1] !== (DECAY_ON ? 16'd6464 : 16'd10)) begin errors++; $display("FAIL bp_bar1: got %0d, required %0d", bars[1], DECAY_ON ? 6464 : 10); end
  endtask

  task automatic test_reset_mid_commit();
    fill(64, 16'd500);
    send_frame(64, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bars[0] !== 16'd0) begin errors++; $display("FAIL rst_mid_bar0: got %0d, required 0", bars[0]); end
    checks++;
    if (mag.mag_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b, required 0", mag.mag_ready); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b, required 0", frame_done); end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (mag.mag_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready: got %b, required 1", mag.mag_ready); end
    fill(64, 16'd0);
    send_frame(64, 1'b0);
    wait_commit();
    pulse_sync();
    checks++;
    if (bars[0] !== 16'd0) begin errors++; $display("FAIL rst_mid_held0: got %0d, required 0", bars[0]); end
    checks++;
    if (bars[5] !== 16'd0) begin errors++; $display("FAIL rst_mid_held5: got %0d, required 0", bars[5]); end
  endtask

  initial begin
    mag.mag_valid = 1'b0;
    mag.mag_data  = 16'd0;
    mag.mag_last  = 1'b0;
    test_reset();
    test_peak();
    test_decay();
    test_gating();
    test_latency();
    test_short_long();
    test_back_to_back();
    test_reset_mid_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bar_accumulator.md
# bar_accumulator

Upstream stage of `bar_display`. Consumes the streamed spectrum-magnitude output (one bin per accepted beat, ending with a last flag), reduces consecutive bins to one peak value per bar, optionally applies peak-hold with linear decay, and presents the bar heights on a double-buffered `bars` array. Published values change only on a frame-sync pulse from the VGA timing logic, so the display never redraws a screen from mixed analysis frames.

## Interface
Parameters:
- `NUM_BARS`, 16, number of output bars; must match the display's bar count.
- `BAR_WIDTH`, 16, bits per bar value and per magnitude sample.
- `BINS_PER_BAR`, 4, consecutive input bins reduced into one bar.
- `DECAY_STEP`, 512, amount subtracted from each held bar per committed frame (used only with `BAR_DECAY_EN`).

Ports:
- `fsm_clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mag_valid`  in  1  magnitude beat valid.
- `mag_data`  in  `BAR_WIDTH`  unsigned bin magnitude.
- `mag_last`  in  1  marks the final bin of an analysis frame; qualified by `mag_valid`.
- `mag_ready`  out  1  block accepts a beat this cycle.
- `frame_sync`  in  1  one-cycle pulse at the start of vertical blanking.
- `bars`  out  `BAR_WIDTH` x `NUM_BARS` (unpacked array, index 0 leftmost)  published bar heights.
- `frame_done`  out  1  one-cycle pulse in the cycle after `bars` is updated.

## Operation
- Beat accepted when `mag_valid && mag_ready`.
- States: ACCUM, COMMIT, WAIT_SYNC. Reset state ACCUM.
- ACCUM: `mag_ready`=1. Bin counter `bin` starts at 0 and increments per accepted beat. Bar index = `bin / BINS_PER_BAR`. If bar index < `NUM_BARS`: `acc[idx] <= max(acc[idx], mag_data)`. Beats with `bin >= NUM_BARS*BINS_PER_BAR` are accepted and discarded. Counter saturates; it does not wrap. Accepted `mag_last` (data still processed) -> COMMIT.
- Early `mag_last`: bars that received no bins keep `acc`=0.
- COMMIT: `mag_ready`=0; exactly `NUM_BARS` cycles, index k=0..NUM_BARS-1, one bar per cycle.
  - With decay: `decayed = (held[k] > DECAY_STEP) ? held[k]-DECAY_STEP : 0`; `held[k] <= max(acc[k], decayed)`.
  - Without decay: `held[k] <= acc[k]`.
  - `acc[k] <= 0` in the same cycle; `bin <= 0` on exit. After k=NUM_BARS-1 -> WAIT_SYNC.
- WAIT_SYNC: `mag_ready`=0. `frame_sync` sampled only in this state; on a high sample, `bars <= held` (all bars in one edge), -> ACCUM. `frame_sync` in ACCUM or COMMIT is ignored; it is not remembered.
- Arithmetic: all unsigned, `BAR_WIDTH` bits; subtraction saturates at 0; no overflow is possible.
- Reset (any time, including mid-COMMIT): state ACCUM, `bin`=0, every `acc`, `held`, `bars` = 0, `frame_done`=0. `mag_ready`=0 while `reset` is high, and 1 from the first cycle after release.

## Timing
- `mag_last` accepted at edge t: COMMIT occupies cycles t+1..t+NUM_BARS, and WAIT_SYNC is entered at t+NUM_BARS+1.
- `frame_sync` high in WAIT_SYNC at cycle s: `bars` changes at edge s+1, `frame_done`=1 during cycle s+1 only, and `mag_ready`=1 from cycle s+1.
- Minimum `mag_last` to `bars` latency: NUM_BARS+2 cycles.
- `bars` is registered and stable between publishes. `mag_ready` is a decode of state only (no combinational path from inputs).

## Configuration
- `BAR_DECAY_EN` defined: peak-hold with `DECAY_STEP` fall per committed frame; `held` persists across frames.
- Not defined: the decay logic is not compiled. `DECAY_STEP` is unused, and each published frame equals that frame's per-bar maxima.

## Test plan
- Reset: assert `reset` mid-COMMIT -> all `bars`=0, `frame_done`=0, `mag_ready`=0; after release `mag_ready`=1 and state ACCUM.
- Peak reduction: 64 bins all 100 except bin 5 = 9000, last on bin 63, then `frame_sync` -> `bars[1]`=9000, others 100; `frame_done` pulses once, exactly 1 cycle after the sync.
- Decay (macro on): the previous frame followed by 64 zero bins -> `bars[1]`=8488, others 0. A third zero frame -> `bars[1]`=7976. Macro off: all 0 after the second frame.
- Publish gating: `frame_sync` pulsed during ACCUM and COMMIT -> `bars` unchanged and `mag_ready` held 0 until a sync arrives in WAIT_SYNC. Measure `mag_last`-to-`bars` latency as 18 cycles with sync already waiting.
- Short/long frames: `mag_last` on bin 9 -> `bars[0..2]` updated, `bars[3..15]`=0 (macro off). An 80-bin frame -> bins 64..79 discarded; no change to `bar[15]` from them.
- Backpressure: `mag_valid` held high through COMMIT/WAIT_SYNC -> no beat consumed while `mag_ready`=0; the next frame's bin 0 lands in bar 0.
